// File: rtl/aux_txn_pkg.sv
// Shared AUX native-transaction types: command/reply codes, FSM states, latched request.
// Also holds the counter-width helper and the request-packet byte builder.
package aux_txn_pkg;

    localparam logic [3:0] AUXNATWR = 4'b1000;
    localparam logic [3:0] AUXNATRD = 4'b1001;

    typedef enum logic [1:0] {
        RPL_ACK   = 2'd0,
        RPL_NACK  = 2'd1,
        RPL_DEFER = 2'd2,
        RPL_BAD   = 2'd3
    } reply_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RDATA  = 3'd3,
        ST_FAIL   = 3'd4,
        ST_GAP    = 3'd5,
        ST_FINISH = 3'd6,
        ST_DRAIN  = 3'd7
    } state_e;

    typedef struct packed {
        logic [19:0] addr;
        logic [7:0]  wdata;
        logic        wr;
    } req_t;

    // Width able to hold 0..n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic logic [7:0] pkt_byte(input req_t req, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {(req.wr ? AUXNATWR : AUXNATRD), req.addr[19:16]};
            3'd1:    b = req.addr[15:8];
            3'd2:    b = req.addr[7:0];
            3'd3:    b = 8'h00;
            default: b = req.wdata;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/aux_txn_if.sv
// Register-side AUX request/response signals plus the byte-level AUX PHY stream.
// slave = transaction engine view, master = requester/PHY view.
interface aux_txn_if;

    logic [19:0] auxaddr;
    logic [7:0]  auxwdata;
    logic        auxwr;
    logic        auxreq;
    logic        auxack;
    logic        auxerr;
    logic [7:0]  auxrdata;
    logic        auxbusy;

    logic [7:0]  phytxdata;
    logic        phytxvalid;
    logic        phytxlast;
    logic        phytxready;
    logic [7:0]  phyrxdata;
    logic        phyrxvalid;
    logic        phyrxlast;
    logic        phyrxerr;

    modport slave (
        input  auxaddr, auxwdata, auxwr, auxreq,
        output auxack, auxerr, auxrdata, auxbusy,
        output phytxdata, phytxvalid, phytxlast,
        input  phytxready,
        input  phyrxdata, phyrxvalid, phyrxlast, phyrxerr
    );

    modport master (
        output auxaddr, auxwdata, auxwr, auxreq,
        input  auxack, auxerr, auxrdata, auxbusy,
        input  phytxdata, phytxvalid, phytxlast,
        output phytxready,
        output phyrxdata, phyrxvalid, phyrxlast, phyrxerr
    );

endinterface

// File: rtl/aux_txn.sv
// Single-byte DPCD native AUX transaction engine with DEFER/timeout retry and a fixed retry gap.
// Latency: auxack one cycle after the final reply byte; TX bytes stall while phytxready is low.
module aux_txn
    import aux_txn_pkg::*;
#(
    parameter int TIMEOUT  = 40000,
    parameter int GAPCYC   = 40000,
    parameter int MAXRETRY = 7
) (
    input  logic     clk,
    input  logic     rst,
    aux_txn_if.slave aux
);

    localparam int TMAX = (TIMEOUT > GAPCYC) ? TIMEOUT : GAPCYC;
    localparam int TW   = cnt_width(TMAX);
    localparam int RW   = cnt_width(MAXRETRY);

    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAPCYC - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAXRETRY);

    state_e        state_q, state_d;
    req_t          req_q, req_d;
    logic [2:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          err_q, err_d;
    logic [7:0]    rdata_q, rdata_d;

    logic [TW-1:0] timer_inc;
    logic [2:0]    idx_last;
    reply_e        rpl;

    assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;
    assign idx_last  = req_q.wr ? 3'd4 : 3'd3;
    assign rpl       = reply_e'(aux.phyrxdata[5:4]);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        retry_d = retry_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (aux.auxreq) begin
                    req_d   = '{addr: aux.auxaddr, wdata: aux.auxwdata, wr: aux.auxwr};
                    idx_d   = 3'd0;
                    retry_d = '0;
                    err_d   = 1'b0;
                    rdata_d = 8'h00;
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                if (aux.phytxready) begin
                    if (idx_q == idx_last) begin
                        idx_d   = 3'd0;
                        timer_d = '0;
                        state_d = ST_WAIT;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            ST_WAIT: begin
                timer_d = timer_inc;
                // A byte arriving in the expiry cycle is still decoded.
                if (aux.phyrxerr) begin
                    state_d = ST_FAIL;
                end else if (aux.phyrxvalid) begin
                    case (rpl)
                        RPL_ACK: begin
                            if (!req_q.wr)          state_d = ST_RDATA;
                            else if (aux.phyrxlast) state_d = ST_FINISH;
                            else                    state_d = ST_FAIL;
                        end
                        RPL_NACK: begin
                            err_d   = 1'b1;
                            state_d = ST_FINISH;
                        end
                        default: state_d = ST_FAIL;
                    endcase
                end else if (timer_q == TO_LAST) begin
                    state_d = ST_FAIL;
                end
            end

            ST_RDATA: begin
                timer_d = timer_inc;
                if (aux.phyrxerr) begin
                    state_d = ST_FAIL;
                end else if (aux.phyrxvalid) begin
                    if (aux.phyrxlast) begin
                        rdata_d = aux.phyrxdata;
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end else if (timer_q == TO_LAST) begin
                    state_d = ST_FAIL;
                end
            end

            ST_FAIL: begin
                if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 1'b1;
                    timer_d = '0;
                    state_d = ST_GAP;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end
            end

            ST_GAP: begin
                timer_d = timer_inc;
                if (timer_q == GAP_LAST) begin
                    idx_d   = 3'd0;
                    state_d = ST_SEND;
                end
            end

            ST_FINISH: state_d = ST_DRAIN;

            ST_DRAIN: begin
                if (!aux.auxreq) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            idx_q   <= 3'd0;
            timer_q <= '0;
            retry_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign aux.phytxvalid = (state_q == ST_SEND);
    assign aux.phytxlast  = (state_q == ST_SEND) && (idx_q == idx_last);
    assign aux.phytxdata  = pkt_byte(req_q, idx_q);

    assign aux.auxack   = (state_q == ST_FINISH);
    assign aux.auxerr   = (state_q == ST_FINISH) && err_q;
    assign aux.auxrdata = ((state_q == ST_FINISH) && !err_q && !req_q.wr) ? rdata_q : 8'h00;
    assign aux.auxbusy  = (state_q != ST_IDLE);

endmodule
